// File: rtl/uart_alu_ctrl_pkg.sv
// Shared definitions for the UART command/response controller: state
// encoding, default widths and the opcode map agreed with the ALU.
package uart_alu_pkg;

   localparam int N_BITS_DEF = 8;
   localparam int N_OP_DEF   = 6;

   typedef enum logic [2:0] {
      ST_WAIT_A  = 3'd0,
      ST_WAIT_B  = 3'd1,
      ST_WAIT_OP = 3'd2,
      ST_EXEC    = 3'd3,
      ST_SEND    = 3'd4,
      ST_WAIT_TX = 3'd5
   } state_t;

   localparam logic [5:0] OP_ADD = 6'h20;
   localparam logic [5:0] OP_SUB = 6'h22;
   localparam logic [5:0] OP_AND = 6'h24;
   localparam logic [5:0] OP_OR  = 6'h25;
   localparam logic [5:0] OP_XOR = 6'h26;
   localparam logic [5:0] OP_SRA = 6'h03;
   localparam logic [5:0] OP_SRL = 6'h02;
   localparam logic [5:0] OP_NOR = 6'h27;

   // The engine is busy from opcode capture until the transmitter reports done.
   function automatic logic is_busy_state(input state_t st);
      logic busy;
      case (st)
         ST_EXEC, ST_SEND, ST_WAIT_TX: busy = 1'b1;
         default:                      busy = 1'b0;
      endcase
      return busy;
   endfunction

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// Bundle of the UART receive/transmit handshakes and the ALU operand/result
// bus. The controller uses the slave view; its environment uses master.
interface uart_alu_ctrl_if #(
   parameter int N_BITS = 8,
   parameter int N_OP   = 6
);
   logic              i_rx_done;
   logic [N_BITS-1:0] i_rx_data;
   logic              i_tx_done;
   logic [N_BITS-1:0] i_alu_result;
   logic [N_BITS-1:0] o_alu_a;
   logic [N_BITS-1:0] o_alu_b;
   logic [N_OP-1:0]   o_alu_op;
   logic              o_tx_start;
   logic [N_BITS-1:0] o_tx_data;
   logic              o_busy;
   logic              o_overrun;

   modport master (
      output i_rx_done, i_rx_data, i_tx_done, i_alu_result,
      input  o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data, o_busy, o_overrun
   );

   modport slave (
      input  i_rx_done, i_rx_data, i_tx_done, i_alu_result,
      output o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data, o_busy, o_overrun
   );
endinterface

// File: rtl/uart_alu_ctrl_timeout.sv
// Inter-byte inactivity counter for the frame controller. Only compiled and
// used when UART_ALU_CTRL_TIMEOUT_EN is defined.
`ifdef UART_ALU_CTRL_TIMEOUT_EN
module ctrl_timeout #(
   parameter int TIMEOUT_CYCLES = 5_000_000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_r;

   // Count enabled cycles since the last clear, saturating at the limit.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         cnt_r <= '0;
      end else if (clear) begin
         cnt_r <= '0;
      end else if (enable && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // A clear in the same cycle (accepted byte) overrides expiry.
   assign expire = enable && !clear && (cnt_r == CNT_MAX);
endmodule
`endif

// File: rtl/uart_alu_ctrl.sv
// Frame controller: collects operand A, operand B and opcode bytes from the
// UART receiver, drives them to an external ALU, and sends the result byte
// back through the UART transmitter. Optional inter-byte timeout is enabled
// with the UART_ALU_CTRL_TIMEOUT_EN macro.
module uart_alu_ctrl
   import uart_alu_pkg::*;
#(
   parameter int N_BITS         = N_BITS_DEF,
   parameter int N_OP           = N_OP_DEF,
   parameter int TIMEOUT_CYCLES = 5_000_000
) (
   input logic            i_clk,
   input logic            i_reset,
   uart_alu_ctrl_if.slave bus
);

   state_t            state_r, state_s;
   logic [N_BITS-1:0] alu_a_r, alu_a_s;
   logic [N_BITS-1:0] alu_b_r, alu_b_s;
   logic [N_OP-1:0]   alu_op_r, alu_op_s;
   logic [N_BITS-1:0] tx_data_r, tx_data_s;
   logic              tx_start_r, tx_start_s;
   logic              busy_r, busy_s;
   logic              overrun_r, overrun_s;
   logic              expire_s;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
   logic to_en_s;
   logic to_clear_s;

   // Only the middle of a frame is timed; any received byte restarts the count.
   assign to_en_s    = (state_r == ST_WAIT_B) || (state_r == ST_WAIT_OP);
   assign to_clear_s = !to_en_s || bus.i_rx_done;

   ctrl_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .clear   (to_clear_s),
      .enable  (to_en_s),
      .expire  (expire_s)
   );
`else
   assign expire_s = 1'b0;
`endif

   // State register.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_r <= ST_WAIT_A;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; a received byte always wins over a coincident timeout.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_WAIT_A: begin
            if (bus.i_rx_done) state_s = ST_WAIT_B;
            else               state_s = ST_WAIT_A;
         end
         ST_WAIT_B: begin
            if (bus.i_rx_done) state_s = ST_WAIT_OP;
            else if (expire_s) state_s = ST_WAIT_A;
            else               state_s = ST_WAIT_B;
         end
         ST_WAIT_OP: begin
            if (bus.i_rx_done) state_s = ST_EXEC;
            else if (expire_s) state_s = ST_WAIT_A;
            else               state_s = ST_WAIT_OP;
         end
         ST_EXEC:    state_s = ST_SEND;
         ST_SEND:    state_s = ST_WAIT_TX;
         ST_WAIT_TX: begin
            if (bus.i_tx_done) state_s = ST_WAIT_A;
            else               state_s = ST_WAIT_TX;
         end
         default:    state_s = ST_WAIT_A;
      endcase
   end

   // Next values of the output registers: captures, result latch and pulses.
   always_comb begin
      alu_a_s   = alu_a_r;
      alu_b_s   = alu_b_r;
      alu_op_s  = alu_op_r;
      tx_data_s = tx_data_r;
      overrun_s = 1'b0;
      case (state_r)
         ST_WAIT_A: begin
            if (bus.i_rx_done) alu_a_s = bus.i_rx_data;
            else               alu_a_s = alu_a_r;
         end
         ST_WAIT_B: begin
            if (bus.i_rx_done) alu_b_s = bus.i_rx_data;
            else               alu_b_s = alu_b_r;
         end
         ST_WAIT_OP: begin
            if (bus.i_rx_done) alu_op_s = bus.i_rx_data[N_OP-1:0];
            else               alu_op_s = alu_op_r;
         end
         ST_EXEC: begin
            tx_data_s = bus.i_alu_result;
            overrun_s = bus.i_rx_done;
         end
         ST_SEND:    overrun_s = bus.i_rx_done;
         ST_WAIT_TX: overrun_s = bus.i_rx_done;
         default:    overrun_s = 1'b0;
      endcase
      tx_start_s = (state_s == ST_SEND);
      busy_s     = is_busy_state(state_s);
   end

   // Output registers; reset clears every output including captured operands.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         alu_a_r    <= '0;
         alu_b_r    <= '0;
         alu_op_r   <= '0;
         tx_data_r  <= '0;
         tx_start_r <= 1'b0;
         busy_r     <= 1'b0;
         overrun_r  <= 1'b0;
      end else begin
         alu_a_r    <= alu_a_s;
         alu_b_r    <= alu_b_s;
         alu_op_r   <= alu_op_s;
         tx_data_r  <= tx_data_s;
         tx_start_r <= tx_start_s;
         busy_r     <= busy_s;
         overrun_r  <= overrun_s;
      end
   end

   assign bus.o_alu_a    = alu_a_r;
   assign bus.o_alu_b    = alu_b_r;
   assign bus.o_alu_op   = alu_op_r;
   assign bus.o_tx_data  = tx_data_r;
   assign bus.o_tx_start = tx_start_r;
   assign bus.o_busy     = busy_r;
   assign bus.o_overrun  = overrun_r;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: directed frames, scoreboard of
// expected responses, monitor comparing on every o_tx_start.
module tb_uart_alu_ctrl;
   import uart_alu_pkg::*;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [5:0] op;
      logic [7:0] data;
   } exp_t;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   int   cyc;
   int   rise_cyc;
   int   tx_cnt;
   int   ovr_cnt;
   logic prev_busy;
   logic prev_tx_start;
   exp_t sb[$];

   uart_alu_ctrl_if #(.N_BITS(8), .N_OP(6)) bus ();

   uart_alu_ctrl #(
      .N_BITS         (8),
      .N_OP           (6),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [5:0] op);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SRA:  return 8'($signed(a) >>> b);
         OP_SRL:  return a >> b;
         OP_NOR:  return ~(a | b);
         default: return 8'h00;
      endcase
   endfunction

   always_comb bus.i_alu_result = alu_model(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      cyc++;
      if (bus.o_overrun) ovr_cnt++;
      if (bus.o_busy && !prev_busy) rise_cyc = cyc;
      if (bus.o_tx_start) begin
         exp_t e;
         tx_cnt++;
         check("tx_start_width", {31'd0, prev_tx_start}, 32'd0);
         check("opcode_to_start", cyc - rise_cyc, 32'd1);
         if (sb.size() == 0) begin
            check("unexpected_tx_start", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("alu_a",   {24'd0, bus.o_alu_a},   {24'd0, e.a});
            check("alu_b",   {24'd0, bus.o_alu_b},   {24'd0, e.b});
            check("alu_op",  {26'd0, bus.o_alu_op},  {26'd0, e.op});
            check("tx_data", {24'd0, bus.o_tx_data}, {24'd0, e.data});
         end
      end
      prev_busy     = bus.o_busy;
      prev_tx_start = bus.o_tx_start;
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Assumes time is just after a rising edge.
   task automatic send_byte(input logic [7:0] d);
      bus.i_rx_done = 1'b1;
      bus.i_rx_data = d;
      idle(1);
      bus.i_rx_done = 1'b0;
   endtask

   // extra: 0 = none, 1 = stray byte while waiting for tx_done,
   //        2 = stray byte coincident with tx_done.
   task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                             input logic [7:0] exp_data, input int extra,
                             input logic [7:0] extra_d);
      exp_t e;
      bit   seen;
      e.a = a; e.b = b; e.op = opb[5:0]; e.data = exp_data;
      sb.push_back(e);
      send_byte(a);   idle(2);
      send_byte(b);   idle(2);
      send_byte(opb);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.o_tx_start) begin
            seen = 1'b1;
            break;
         end
         idle(1);
      end
      check("tx_start_seen", {31'd0, seen}, 32'd1);
      idle(2);
      if (extra == 1) begin
         send_byte(extra_d);
         idle(2);
         check("busy_after_overrun", {31'd0, bus.o_busy}, 32'd1);
      end
      bus.i_tx_done = 1'b1;
      if (extra == 2) begin
         bus.i_rx_done = 1'b1;
         bus.i_rx_data = extra_d;
      end
      idle(1);
      bus.i_tx_done = 1'b0;
      bus.i_rx_done = 1'b0;
      idle(2);
      check("busy_after_done", {31'd0, bus.o_busy}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      vectors = 0; miscompares = 0; cyc = 0; rise_cyc = 0;
      tx_cnt = 0; ovr_cnt = 0; prev_busy = 1'b0; prev_tx_start = 1'b0;
      bus.i_rx_done = 1'b0; bus.i_rx_data = 8'h00;
      bus.i_tx_done = 1'b0;
      rst_n = 1'b0;
      idle(3);
      check("reset_outputs",
            {bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_start, bus.o_busy, bus.o_overrun},
            32'd0);
      check("reset_tx_data", {24'd0, bus.o_tx_data}, 32'd0);
      rst_n = 1'b1;
      idle(2);

      // Basic frame and wrap-around with high opcode bits.
      send_frame(8'h05, 8'h03, 8'h20, 8'h08, 0, 8'h00);
      send_frame(8'hFF, 8'h01, 8'hE2, 8'hFE, 1, 8'hAA);
      check("overrun_count_1", ovr_cnt, 32'd1);
      check("stable_a",  {24'd0, bus.o_alu_a},  32'h0000_00FF);
      check("stable_op", {26'd0, bus.o_alu_op}, 32'h0000_0022);
      send_frame(8'h0C, 8'h0A, 8'h24, 8'h08, 0, 8'h00);

      // Reset after A and B: frame aborted, no transmit.
      t0 = tx_cnt;
      send_byte(8'h11); idle(2);
      send_byte(8'h22); idle(2);
      rst_n = 1'b0;
      idle(2);
      check("midreset_outputs",
            {bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_start, bus.o_busy, bus.o_overrun},
            32'd0);
      check("midreset_tx_data", {24'd0, bus.o_tx_data}, 32'd0);
      rst_n = 1'b1;
      idle(10);
      check("midreset_no_tx", tx_cnt, t0);
      send_frame(8'h05, 8'h03, 8'h20, 8'h08, 0, 8'h00);

      // Back-to-back: byte coincident with tx_done is dropped.
      send_frame(8'h0F, 8'h33, 8'h26, 8'h3C, 2, 8'h77);
      check("overrun_count_2", ovr_cnt, 32'd2);
      send_frame(8'h10, 8'h04, 8'h02, 8'h01, 0, 8'h00);
      send_frame(8'h80, 8'h02, 8'h03, 8'hE0, 0, 8'h00);
      send_frame(8'h5A, 8'hA5, 8'h27, 8'h00, 0, 8'h00);
      check("overrun_count_3", ovr_cnt, 32'd2);

`ifdef UART_ALU_CTRL_TIMEOUT_EN
      // Partial frame abandoned after the inactivity limit.
      send_byte(8'h01);
      idle(110);
      check("timeout_keep_a", {24'd0, bus.o_alu_a}, 32'h0000_0001);
      check("timeout_not_busy", {31'd0, bus.o_busy}, 32'd0);
      send_frame(8'h02, 8'h02, 8'h20, 8'h04, 0, 8'h00);
      check("timeout_no_overrun", ovr_cnt, 32'd2);
`endif

      idle(5);
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Frame controller that sequences the UART loopback datapath into a command/response engine. It collects three received bytes (operand A, operand B, opcode), presents them to an external ALU, captures the result and hands it to the UART transmitter as a single response byte. It sits between `rx_uart`/`tx_uart` and the ALU, replacing the direct `rx_done`→`tx_start` loopback wiring.

## Interface

- `N_BITS`, 8: data width of UART bytes, operands and result.
- `N_OP`, 6: opcode width; the low `N_OP` bits of the third byte.
- `TIMEOUT_CYCLES`, 5_000_000: inter-byte inactivity limit in `i_clk` cycles; used only with the timeout feature.

Ports:

- `i_clk` in 1: system clock.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_rx_done` in 1: one-cycle pulse, byte valid on `i_rx_data`.
- `i_rx_data` in N_BITS: received byte.
- `i_tx_done` in 1: one-cycle pulse, transmitter finished its frame.
- `i_alu_result` in N_BITS: combinational ALU output.
- `o_alu_a` out N_BITS: operand A register.
- `o_alu_b` out N_BITS: operand B register.
- `o_alu_op` out N_OP: opcode register.
- `o_tx_start` out 1: one-cycle start pulse to the transmitter.
- `o_tx_data` out N_BITS: result byte to transmit, held stable until `i_tx_done`.
- `o_busy` out 1: high from opcode capture until `i_tx_done`.
- `o_overrun` out 1: one-cycle pulse when a received byte is dropped.

## Operation

- **Reset state:** while `i_reset`=0, all outputs are 0 and the state is `WAIT_A`.
- **State machine:** `WAIT_A` → `WAIT_B` → `WAIT_OP` → `EXEC` → `SEND` → `WAIT_TX` → `WAIT_A`.
- **`WAIT_A`, `WAIT_B`, `WAIT_OP`:** on `i_rx_done`, latch `i_rx_data` into A, B or OP respectively (OP = `i_rx_data[N_OP-1:0]`, upper bits ignored) and advance. Without `i_rx_done`, hold.
- **`EXEC`:** one cycle for the ALU to settle. Latch `i_alu_result` into `o_tx_data` and go to `SEND`.
- **`SEND`:** `o_tx_start`=1 for exactly this cycle, then go to `WAIT_TX`.
- **`WAIT_TX`:** hold until `i_tx_done`, then return to `WAIT_A`.
- **Dropped bytes:** `i_rx_done` in `EXEC`, `SEND` or `WAIT_TX` drops the byte, pulses `o_overrun`, and leaves the state unchanged.
- **Register stability:** `o_alu_a`, `o_alu_b` and `o_alu_op` keep their last values after a frame completes. They change only on capture.
- **Arithmetic:** none in this block. Overflow and width rules belong to the ALU, and `o_tx_data` is exactly `N_BITS` wide.
- **Simultaneous events:** `i_tx_done` and `i_rx_done` in the same cycle while in `WAIT_TX` returns to `WAIT_A`. That byte counts as dropped (`o_overrun` pulses) and is not captured as A.
- **Reset mid-frame:** asserting reset during any state aborts the frame immediately. No `o_tx_start` is issued afterwards.

## Timing

- Opcode capture to `o_tx_start`: 2 cycles (`EXEC`, `SEND`). `o_tx_start` is high in the second clock edge after the opcode-capturing edge.
- `o_busy` rises on the edge that captures the opcode and falls on the edge that consumes `i_tx_done`.
- Minimum frame period: 3 rx bytes plus 1 tx byte on the serial line. The controller adds 3 clock cycles of overhead.
- All outputs are registered.

## Configuration

- `UART_ALU_CTRL_TIMEOUT_EN` **defined:** in `WAIT_B` and `WAIT_OP`, a counter starts at 0 on each accepted byte and increments every cycle.
  - When it reaches `TIMEOUT_CYCLES`, the state returns to `WAIT_A` and the partial frame is discarded.
  - Captured registers keep their values, and `o_overrun` does not pulse.
  - `i_rx_done` on the expiry cycle takes priority: the byte is accepted and the counter clears.
- `UART_ALU_CTRL_TIMEOUT_EN` **undefined:** no counter exists and partial frames wait indefinitely.

## Structure

- **Shared package `uart_alu_pkg`:** state encoding constants, `N_OP` default, and opcode constants shared with the ALU and benches (ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, XOR 6'h26, SRA 6'h03, SRL 6'h02, NOR 6'h27).
- **Sub-module `ctrl_timeout`:** the inactivity counter, with clear/enable inputs and an expiry pulse output. It is instantiated only under `UART_ALU_CTRL_TIMEOUT_EN`.

## Test plan

- **Basic frame:** rx 0x05, 0x03, 0x20 with the bench ALU computing ADD → `o_alu_a`=0x05, `o_alu_b`=0x03, `o_alu_op`=0x20; `o_tx_start` pulses once 2 cycles after the opcode; `o_tx_data`=0x08.
- **Wrap-around and high opcode bits:** rx 0xFF, 0x01, 0xE2 (SUB, upper bits set) → `o_alu_op`=0x22; `o_tx_data`=0xFE.
- **Overrun:** extra rx byte 0xAA during `WAIT_TX` → `o_overrun` pulses once, no state change. The next frame 0x0C, 0x0A, 0x24 yields 0x08.
- **Reset mid-frame:** assert reset after A and B are received → all outputs 0, no tx pulse. A following full frame behaves as the basic frame.
- **Back-to-back frames:** `i_tx_done` coincident with the next rx byte → that byte is dropped with `o_overrun`. The following bytes form a correct frame.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=100):** rx 0x01, then idle for 100 cycles → state returns to `WAIT_A`. The next 3 bytes 0x02, 0x02, 0x20 give 0x04.
